synapse_accumulator: RTL and testbench

Time-multiplexed synaptic front end that feeds the `current` input of the leaky integrate-and-fire neuron. On each `start` it snapshots a vector of presynaptic spikes. It then walks the inputs one per clock through a single shared adder, summing the programmable weight of every input that spiked. The saturated 8-bit sum is presented as `current` with a one-cycle valid strobe.

---
 rtl/lif_pkg.sv | 17 +
 rtl/synapse_accumulator_if.sv | 30 +++
 rtl/synapse_weight_rf.sv | 43 ++++
 rtl/synapse_accumulator.sv | 108 ++++++++++
 tb/tb_synapse_accumulator.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/lif_pkg.sv
// lif_pkg
//   Shared definitions for the leaky integrate-and-fire neuron and its
//   synaptic front end.
//   - CURRENT_W / CURRENT_MAX : width and ceiling of the neuron input current.
//   - syn_state_t             : frame sequencer states of synapse_accumulator.
package lif_pkg;

  localparam int CURRENT_W   = 8;
  localparam int CURRENT_MAX = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } syn_state_t;

endpackage

// File: rtl/synapse_accumulator_if.sv
// synapse_accumulator_if
//   Bundles the synaptic front-end signals.
//   master (driver side): spikes_in, start, wr_en, wr_addr, wr_data out;
//                         current, current_valid, busy in.
//   slave  (accumulator): the mirror image.
interface synapse_accumulator_if #(
  parameter int N_INPUTS = 8,
  parameter int ADDR_W   = $clog2(N_INPUTS)
);

  logic [N_INPUTS-1:0] spikes_in;
  logic                start;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [7:0]          wr_data;
  logic [7:0]          current;
  logic                current_valid;
  logic                busy;

  modport master (
    output spikes_in, start, wr_en, wr_addr, wr_data,
    input  current, current_valid, busy
  );

  modport slave (
    input  spikes_in, start, wr_en, wr_addr, wr_data,
    output current, current_valid, busy
  );

endinterface

// File: rtl/synapse_weight_rf.sv
// synapse_weight_rf
//   N_INPUTS x 8-bit unsigned weight registers.
//   clk, rst_n          : clock, synchronous active-low reset (weights -> 0).
//   wr_en/wr_addr/wr_data: synchronous write; addresses >= N_INPUTS dropped.
//   rd_addr -> rd_data  : combinational read (value before the current edge).
module synapse_weight_rf #(
  parameter int N_INPUTS = 8,
  parameter int ADDR_W   = $clog2(N_INPUTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [N_INPUTS-1:0][7:0] weight_vec;
  logic                     wr_in_range;

  // Widen by one bit so the comparison also works when N_INPUTS == 2**ADDR_W.
  assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(N_INPUTS));

  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : gen_weight
      logic [7:0] weight_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          weight_reg <= 8'd0;
        end else if (wr_en && wr_in_range && (wr_addr == ADDR_W'(gi))) begin
          weight_reg <= wr_data;
        end
      end

      assign weight_vec[gi] = weight_reg;
    end
  endgenerate

  assign rd_data = weight_vec[rd_addr];

endmodule

// File: rtl/synapse_accumulator.sv
// synapse_accumulator
//   Time-multiplexed weighted spike sum feeding the neuron current input.
//   A start in IDLE snapshots spikes_in, then one input per clock is added
//   (if it spiked) through a single adder; the saturated sum is registered
//   onto current with a one-cycle current_valid pulse.
//   clk, rst_n : clock, synchronous active-low reset.
//   bus        : synapse_accumulator_if slave (spikes_in, start, weight write
//                port in; current, current_valid, busy out).
module synapse_accumulator
  import lif_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int ADDR_W   = $clog2(N_INPUTS)
) (
  input logic                 clk,
  input logic                 rst_n,
  synapse_accumulator_if.slave bus
);

  // One spare bit beyond 8 + ADDR_W so N_INPUTS * 255 can never wrap.
  localparam int ACC_W = CURRENT_W + ADDR_W + 1;

  syn_state_t               state_reg, state_next;
  logic [ADDR_W-1:0]        idx_reg, idx_next;
  logic [ACC_W-1:0]         acc_reg, acc_next;
  logic [N_INPUTS-1:0]      spk_reg, spk_next;
  logic [CURRENT_W-1:0]     current_reg, current_next;
  logic                     valid_reg, valid_next;
  logic [7:0]               weight_rd;

  synapse_weight_rf #(
    .N_INPUTS (N_INPUTS),
    .ADDR_W   (ADDR_W)
  ) u_weight_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (idx_reg),
    .rd_data (weight_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      acc_reg     <= '0;
      spk_reg     <= '0;
      current_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      acc_reg     <= acc_next;
      spk_reg     <= spk_next;
      current_reg <= current_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    acc_next     = acc_reg;
    spk_next     = spk_reg;
    current_next = current_reg;
    valid_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          spk_next   = bus.spikes_in;
          idx_next   = '0;
          acc_next   = '0;
          state_next = ACCUM;
        end
      end

      ACCUM: begin
        if (spk_reg[idx_reg]) begin
          acc_next = acc_reg + ACC_W'(weight_rd);
        end
        if (idx_reg == ADDR_W'(N_INPUTS-1)) begin
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end

      DONE: begin
        current_next = (acc_reg > ACC_W'(CURRENT_MAX)) ? CURRENT_W'(CURRENT_MAX)
                                                       : acc_reg[CURRENT_W-1:0];
        valid_next   = 1'b1;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.current       = current_reg;
  assign bus.current_valid = valid_reg;
  assign bus.busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_synapse_accumulator.sv
// tb_synapse_accumulator
//   Directed-vector bench for synapse_accumulator (N_INPUTS = 8). Inputs are
//   driven and outputs sampled on the falling edge; edge numbers below count
//   rising edges after the one that accepts start (edge 0).
module tb_synapse_accumulator;

  localparam int N = 8;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  synapse_accumulator_if #(.N_INPUTS(N)) bus ();

  synapse_accumulator #(.N_INPUTS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on a falling edge.
  task automatic write_w(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_data = 8'(data);
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // mode 0: plain frame
  // mode 1: spikes_in -> FF and a second start pulse mid-frame (edge 3)
  // mode 2: write w7=50 at edge 2 and w0=50 at edge 5
  // mode 3: reset asserted at edge 4, released at edge 6
  task automatic run_frame(input string tag, input logic [7:0] spk,
                           input int exp, input int mode);
    int vcount;
    int vedge;
    logic busy8;
    logic busy10;
    vcount = 0;
    vedge  = -1;
    busy8  = 1'b0;
    busy10 = 1'b1;
    bus.spikes_in = spk;
    bus.start     = 1'b1;
    @(posedge clk);            // edge 0
    @(negedge clk);
    bus.start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.current_valid) begin
        vcount++;
        vedge = e;
      end
      if (e == 8)  busy8  = bus.busy;
      if (e == 10) busy10 = bus.busy;
      bus.wr_en = 1'b0;
      if (mode == 1 && e == 2) begin
        bus.spikes_in = 8'hFF;
        bus.start     = 1'b1;
      end
      if (mode == 1 && e == 3) bus.start = 1'b0;
      if (mode == 2 && e == 1) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 8'd50;
      end
      if (mode == 2 && e == 4) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'd50;
      end
      if (mode == 3 && e == 3) rst_n = 1'b0;
      if (mode == 3 && e == 5) rst_n = 1'b1;
    end
    $display("frame %s: current=%0d valid_pulses=%0d valid_edge=%0d",
             tag, bus.current, vcount, vedge);
    check_val({tag, "_current"}, 32'(bus.current), 32'(exp));
    if (mode == 3) begin
      check_val({tag, "_valid_count"}, 32'(vcount), 32'd0);
      check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
    end else begin
      check_val({tag, "_valid_count"}, 32'(vcount), 32'd1);
      check_val({tag, "_valid_edge"}, 32'(vedge), 32'd9);
      check_val({tag, "_busy_edge8"}, 32'(busy8), 32'd1);
      check_val({tag, "_busy_edge10"}, 32'(busy10), 32'd0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.spikes_in = '0;
    bus.start     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_current", 32'(bus.current), 32'd0);
    check_val("rst_valid", 32'(bus.current_valid), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // w[i] = 10*(i+1); spikes on 0 and 2 -> 10 + 30
    for (int i = 0; i < N; i++) write_w(i, 10 * (i + 1));
    run_frame("basic", 8'b0000_0101, 40, 0);
    @(negedge clk);
    check_val("hold_current", 32'(bus.current), 32'd40);

    // 8 * 200 = 1600 saturates to 255
    for (int i = 0; i < N; i++) write_w(i, 200);
    run_frame("saturate", 8'hFF, 255, 0);

    // only input 0 captured; mid-frame FF and start ignored
    write_w(0, 7);
    run_frame("snapshot", 8'h01, 7, 1);

    // w7 change before visit counts, w0 change after visit does not: 7*1 + 50
    for (int i = 0; i < N; i++) write_w(i, 1);
    run_frame("wr_during", 8'hFF, 57, 2);

    // restore weights to nonzero before aborting, then prove they cleared
    for (int i = 0; i < N; i++) write_w(i, 1);
    run_frame("rst_mid", 8'hFF, 0, 3);
    run_frame("post_rst_w", 8'hFF, 0, 0);
    run_frame("empty", 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
